// File: rtl/rlc_decoder.sv
// rlc_decoder: rebuilds one 8x8 block from (run, level) symbols.
// DC arrives first, then AC symbols in zigzag order until EOB or position 63.
// The finished raster-ordered block is held on coef_out until downstream takes it.

// One coefficient register of the block buffer.
module rlc_coef_cell #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over a write; the two never coincide in practice.
  always_ff @(posedge clk) begin
    if (srst || clr) q <= '0;
    else if (we)     q <= d;
  end

endmodule

module rlc_decoder #(
  parameter int N  = 10,
  parameter int RW = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic [RW-1:0]         sym_run,
  input  logic [N:0]            sym_level,
  input  logic                  sym_eob,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [64*(N+1)-1:0]   coef_out,
  output logic                  blk_err
);

  localparam int W = N + 1;

  typedef enum logic [1:0] {S_DC, S_AC, S_FLUSH, S_OUT} state_t;

  state_t      state, state_d;
  logic [6:0]  pos, pos_d;
  logic [6:0]  tgt;
  logic        accept;
  logic        wr_en;
  logic [5:0]  wr_zz;
  logic [5:0]  wr_raster;
  logic        err_set;
  logic        clr;
  logic [63:0] cell_we;

  // Standard JPEG zigzag index -> raster index.
  function automatic logic [5:0] zz2raster(input logic [5:0] z);
    logic [5:0] r;
    case (z)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  assign sym_ready = (state != S_OUT);
  assign blk_valid = (state == S_OUT);
  assign accept    = sym_valid & sym_ready;
  // 7 bits holds the worst case 63 + 15 without wrapping.
  assign tgt       = pos + 7'(sym_run);
  assign wr_raster = zz2raster(wr_zz);

  // State register.
  always_ff @(posedge clk) begin
    if (srst) state <= S_DC;
    else      state <= state_d;
  end

  // Next state, write strobe, position update and error detection.
  always_comb begin
    state_d = state;
    pos_d   = pos;
    wr_en   = 1'b0;
    wr_zz   = 6'd0;
    err_set = 1'b0;
    clr     = 1'b0;
    case (state)
      S_DC: begin
        if (accept) begin
          wr_en   = 1'b1;
          pos_d   = 7'd1;
          state_d = S_AC;
        end
      end
      S_AC: begin
        if (accept) begin
          if (sym_eob) begin
            state_d = S_OUT;
          end else if (tgt <= 7'd63) begin
            wr_en = 1'b1;
            wr_zz = tgt[5:0];
            pos_d = tgt + 7'd1;
            if (tgt == 7'd63) state_d = S_OUT;
          end else begin
            err_set = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (accept && sym_eob) state_d = S_OUT;
      end
      S_OUT: begin
        if (blk_ready) begin
          clr     = 1'b1;
          pos_d   = 7'd0;
          state_d = S_DC;
        end
      end
      default: state_d = S_DC;
    endcase
  end

  // Position counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (srst) begin
      pos     <= 7'd0;
      blk_err <= 1'b0;
    end else begin
      pos <= pos_d;
      if (clr)          blk_err <= 1'b0;
      else if (err_set) blk_err <= 1'b1;
    end
  end

  // Block buffer: one register per raster position.
  for (genvar g = 0; g < 64; g++) begin : g_cell
    assign cell_we[g] = wr_en && (wr_raster == 6'(g));
    rlc_coef_cell #(.W(W)) u_cell (
      .clk  (clk),
      .srst (srst),
      .clr  (clr),
      .we   (cell_we[g]),
      .d    (sym_level),
      .q    (coef_out[g*W +: W])
    );
  end

endmodule

// File: tb/tb_rlc_decoder.sv
// Directed bench for rlc_decoder: vector table plus hand-written block sequences.
module tb_rlc_decoder;

  localparam int N = 10;
  localparam int RW = 4;
  localparam int W = N + 1;

  logic              clk = 1'b0;
  logic              srst;
  logic              sym_valid;
  logic              sym_ready;
  logic [RW-1:0]     sym_run;
  logic [N:0]        sym_level;
  logic              sym_eob;
  logic              blk_valid;
  logic              blk_ready;
  logic [64*W-1:0]   coef_out;
  logic              blk_err;

  int n_chk = 0;
  int n_fail = 0;
  int zz[64];
  int exp_blk[64];

  rlc_decoder #(.N(N), .RW(RW)) dut (
    .clk(clk), .srst(srst), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_run(sym_run), .sym_level(sym_level), .sym_eob(sym_eob),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .coef_out(coef_out),
    .blk_err(blk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int run; int lvl; bit eob; bit brdy;
    bit rdy; bit bv; bit err; int idx; int val; int nz;
  } vec_t;

  vec_t tbl[9];

  function automatic int coef(input int idx);
    logic [W-1:0] c;
    c = coef_out[idx*W +: W];
    return int'($signed(c));
  endfunction

  function automatic int nz_count();
    int n = 0;
    for (int i = 0; i < 64; i++) if (coef(i) != 0) n++;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_block(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 64; i++)
      if (coef(i) != exp_blk[i]) begin bad++; if (first < 0) first = i; end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d coefficients wrong, first raster %0d got %0d expected %0d",
               name, bad, first, coef(first), exp_blk[first]);
    end
  endtask

  task automatic step(input bit v, input int run, input int lvl, input bit eob, input bit brdy);
    sym_valid = v;
    sym_run   = RW'(run);
    sym_level = W'(lvl);
    sym_eob   = eob;
    blk_ready = brdy;
    @(posedge clk); #1;
  endtask

  task automatic chk_flags(input string name, input bit rdy, input bit bv, input bit err);
    chk({name, ".sym_ready"}, int'(sym_ready), int'(rdy));
    chk({name, ".blk_valid"}, int'(blk_valid), int'(bv));
    if (bv) chk({name, ".blk_err"}, int'(blk_err), int'(err));
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_blk[i] = 0;
  endtask

  initial begin
    zz = '{0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,
           7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,
           39,46,53,60,61,54,47,55,62,63};

    //            v run lvl eob brdy | rdy bv err idx val nz
    tbl[0] = '{1, 0, 37, 0, 0,  1, 0, 0, 0, 37, 1};   // DC 37
    tbl[1] = '{1, 0, 0,  1, 0,  0, 1, 0, 0, 37, 1};   // EOB -> valid next cycle
    tbl[2] = '{0, 0, 0,  0, 1,  1, 0, 0, 0, 0,  0};   // handshake clears
    tbl[3] = '{1, 0, -5, 0, 0,  1, 0, 0, 0, -5, 1};   // DC -5
    tbl[4] = '{1, 0, 3,  0, 0,  1, 0, 0, 1, 3,  2};   // zz1 -> raster1
    tbl[5] = '{1, 1, -2, 0, 0,  1, 0, 0, 16, -2, 3};  // zz3 -> raster16
    tbl[6] = '{1, 0, 0,  1, 0,  0, 1, 0, 16, -2, 3};  // EOB
    tbl[7] = '{1, 3, 9,  0, 0,  0, 1, 0, 1, 3,  3};   // held, symbol ignored
    tbl[8] = '{0, 0, 0,  0, 1,  1, 0, 0, 16, 0, 0};   // handshake

    srst = 1'b1; sym_valid = 0; sym_run = 0; sym_level = 0; sym_eob = 0; blk_ready = 0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    chk_flags("reset", 1, 0, 0);
    chk("reset.blk_err", int'(blk_err), 0);
    chk("reset.nz", nz_count(), 0);

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      step(tbl[i].v, tbl[i].run, tbl[i].lvl, tbl[i].eob, tbl[i].brdy);
      chk_flags(nm, tbl[i].rdy, tbl[i].bv, tbl[i].err);
      chk({nm, ".coef"}, coef(tbl[i].idx), tbl[i].val);
      chk({nm, ".nz"}, nz_count(), tbl[i].nz);
    end

    // Full block without EOB: ends on zigzag 63.
    clear_exp();
    exp_blk[0] = 1;
    step(1, 0, 1, 0, 0);
    for (int k = 1; k <= 63; k++) begin
      exp_blk[zz[k]] = k;
      if (k == 63) chk("full.rdy_before_last", int'(sym_ready), 1);
      step(1, 0, k, 0, 0);
      if (k == 62) chk("full.bv_before_last", int'(blk_valid), 0);
    end
    chk_flags("full", 0, 1, 0);
    chk("full.r63", coef(63), 63);
    chk("full.r62", coef(62), 62);
    chk_block("full.block");

    // Back-pressure: 10 cycles of blk_ready low with symbols offered.
    for (int c = 0; c < 10; c++) step(1, 0, 99, 0, 0);
    chk_flags("hold", 0, 1, 0);
    chk_block("hold.block");
    // Handshake cycle: DC offered but not accepted.
    step(1, 0, 99, 0, 1);
    chk_flags("release", 1, 0, 0);
    chk("release.nz", nz_count(), 0);
    step(1, 0, 99, 0, 0);
    chk("next_dc.r0", coef(0), 99);
    chk("next_dc.nz", nz_count(), 1);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // ZRL chain: 1 -> 17 -> 33 -> 49, then run 13 lands on zigzag 62.
    step(1, 0, 0, 0, 0);
    for (int z = 0; z < 3; z++) step(1, 15, 0, 0, 0);
    step(1, 13, 7, 0, 0);
    chk("zrl.bv_pre_eob", int'(blk_valid), 0);
    step(1, 0, 0, 1, 0);
    chk_flags("zrl", 0, 1, 0);
    chk("zrl.r62", coef(62), 7);
    chk("zrl.nz", nz_count(), 1);
    step(0, 0, 0, 0, 1);

    // Overflow: reach pos 63, then run 15 overshoots to 78.
    step(1, 0, 0, 0, 0);
    for (int z = 0; z < 3; z++) step(1, 15, 0, 0, 0);
    step(1, 13, 9, 0, 0);
    step(1, 15, 1, 0, 0);
    chk_flags("ovf", 1, 0, 0);
    step(1, 0, 5, 0, 0);
    step(1, 2, 6, 0, 0);
    chk("flush.bv", int'(blk_valid), 0);
    chk("flush.nz", nz_count(), 1);
    step(1, 0, 0, 1, 0);
    chk_flags("ovf_done", 0, 1, 1);
    chk("ovf.r62", coef(62), 9);
    chk("ovf.r63", coef(63), 0);
    step(0, 0, 0, 0, 1);
    chk_flags("ovf_clear", 1, 0, 0);
    chk("ovf_clear.err", int'(blk_err), 0);

    // Reset mid-block, then a clean block.
    step(1, 0, 4, 0, 0);
    for (int k = 1; k <= 5; k++) step(1, 0, k + 10, 0, 0);
    srst = 1'b1;
    step(1, 0, 0, 1, 1);
    srst = 1'b0;
    chk_flags("srst", 1, 0, 0);
    chk("srst.err", int'(blk_err), 0);
    chk("srst.nz", nz_count(), 0);
    clear_exp();
    exp_blk[0] = 2; exp_blk[1] = 8;
    step(1, 0, 2, 0, 0);
    step(1, 0, 8, 0, 0);
    step(1, 0, 0, 1, 0);
    chk_flags("post_srst", 0, 1, 0);
    chk_block("post_srst.block");
    step(0, 0, 0, 0, 1);
    chk("post_srst.bv_clear", int'(blk_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
